// File: rtl/column_buffer_ctrl.sv
// rtl/column_buffer_ctrl.sv - double-buffered column-height store and frame sequencer
// Optional: define HEIGHT_CLAMP_EN to clamp stored heights to V_ROWS.
module column_buffer_ctrl #(
    parameter int H_COLS   = 700,
    parameter int V_ROWS   = 500,
    parameter int COL_W    = 10,
    parameter int HEIGHT_W = 10
) (
    input  logic                half_clk,
    input  logic                rst_n,
    input  logic                frame_start,
    output logic                frame_req,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [HEIGHT_W-1:0] wr_height,
    output logic [COL_W-1:0]    wr_col,
    input  logic [COL_W-1:0]    rd_col,
    output logic [HEIGHT_W-1:0] rd_height,
    output logic                disp_sel,
    output logic                disp_valid,
    output logic                overrun
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_COLS - 1);
    localparam logic [COL_W:0]   NUM_COLS = (COL_W + 1)'(H_COLS);

    state_t              state_q;
    logic [COL_W-1:0]    wr_col_q;
    logic                disp_sel_q;
    logic                disp_valid_q;
    logic                frame_req_q;
    logic                wr_ready_q;
    logic                overrun_q;
    logic [HEIGHT_W-1:0] rd_height_q;

    logic [HEIGHT_W-1:0] bank0_q [H_COLS];
    logic [HEIGHT_W-1:0] bank1_q [H_COLS];

    logic                accept;
    logic                last_beat;
    logic                rd_in_range;
    logic [HEIGHT_W-1:0] wr_data;
    logic [HEIGHT_W-1:0] rd_data;

    // wr_ready_q is only ever high in FILL, so a handshake implies FILL.
    assign accept      = wr_valid && wr_ready_q;
    assign last_beat   = accept && (wr_col_q == LAST_COL);
    assign rd_in_range = ({1'b0, rd_col} < NUM_COLS);

`ifdef HEIGHT_CLAMP_EN
    assign wr_data = (wr_height > HEIGHT_W'(V_ROWS)) ? HEIGHT_W'(V_ROWS) : wr_height;
`else
    assign wr_data = wr_height;
`endif

    assign rd_data = disp_sel_q ? bank1_q[rd_col] : bank0_q[rd_col];

    // REQ spends one extra cycle after reset so frame_req is low during reset
    // and pulses on the first cycle after release; a swap enters REQ with the
    // pulse already raised.
    always_ff @(posedge half_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            wr_col_q     <= '0;
            disp_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            frame_req_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_req_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                ST_REQ: begin
                    wr_col_q  <= '0;
                    overrun_q <= frame_start;
                    if (frame_req_q) begin
                        state_q    <= ST_FILL;
                        wr_ready_q <= 1'b1;
                    end else begin
                        frame_req_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (last_beat) begin
                        wr_ready_q <= 1'b0;
                        if (frame_start) begin
                            disp_sel_q   <= ~disp_sel_q;
                            disp_valid_q <= 1'b1;
                            frame_req_q  <= 1'b1;
                            wr_col_q     <= '0;
                            state_q      <= ST_REQ;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        overrun_q <= frame_start;
                        if (accept) begin
                            wr_col_q <= wr_col_q + COL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_start) begin
                        disp_sel_q   <= ~disp_sel_q;
                        disp_valid_q <= 1'b1;
                        frame_req_q  <= 1'b1;
                        wr_col_q     <= '0;
                        state_q      <= ST_REQ;
                    end
                end
                default: begin
                    state_q    <= ST_REQ;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Bank contents are deliberately not reset; the back bank is always bank ~disp_sel.
    always_ff @(posedge half_clk) begin
        if (accept) begin
            if (disp_sel_q) begin
                bank0_q[wr_col_q] <= wr_data;
            end else begin
                bank1_q[wr_col_q] <= wr_data;
            end
        end
    end

    always_ff @(posedge half_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_height_q <= '0;
        end else begin
            rd_height_q <= (disp_valid_q && rd_in_range) ? rd_data : '0;
        end
    end

    assign frame_req  = frame_req_q;
    assign wr_ready   = wr_ready_q;
    assign wr_col     = wr_col_q;
    assign rd_height  = rd_height_q;
    assign disp_sel   = disp_sel_q;
    assign disp_valid = disp_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_column_buffer_ctrl.sv
// tb/tb_column_buffer_ctrl.sv - self-checking bench for column_buffer_ctrl
module tb_column_buffer_ctrl;

    logic       half_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic       frame_start = 1'b0;
    logic       wr_valid    = 1'b0;
    logic [9:0] wr_height   = '0;
    logic [9:0] rd_col      = '0;
    logic       frame_req;
    logic       wr_ready;
    logic [9:0] wr_col;
    logic [9:0] rd_height;
    logic       disp_sel;
    logic       disp_valid;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    column_buffer_ctrl dut (
        .half_clk    (half_clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_req   (frame_req),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_height   (wr_height),
        .wr_col      (wr_col),
        .rd_col      (rd_col),
        .rd_height   (rd_height),
        .disp_sel    (disp_sel),
        .disp_valid  (disp_valid),
        .overrun     (overrun)
    );

    always #5 half_clk = ~half_clk;

`ifdef HEIGHT_CLAMP_EN
    localparam int EXP_900 = 500;
`else
    localparam int EXP_900 = 900;
`endif

    // Model: banks as arrays, the frame as a count of accepted beats.
    int   m_bank [2][700];
    logic m_sel, m_valid, m_fresh, m_req, m_ready, e_overrun;
    int   m_count;
    int   e_rd;

    function automatic int clamp_h(input int h);
`ifdef HEIGHT_CLAMP_EN
        return (h > 500) ? 500 : h;
`else
        return h;
`endif
    endfunction

    function automatic logic [9:0] height_of(input int mode, input int col);
        case (mode)
            0:       return 10'(col);
            1:       return (col == 5) ? 10'd900 : 10'((col * 3) % 1024);
            default: return 10'(699 - col);
        endcase
    endfunction

    task automatic model_reset();
        m_sel = 1'b0; m_valid = 1'b0; m_fresh = 1'b1;
        m_req = 1'b0; m_ready = 1'b0; e_overrun = 1'b0;
        m_count = 0; e_rd = 0;
    endtask

    task automatic model_edge();
        logic complete, swap, nready, nreq;
        e_rd = (m_valid && int'(rd_col) < 700) ? m_bank[m_sel][int'(rd_col)] : 0;
        if (wr_valid && m_ready) begin
            m_bank[!m_sel][m_count] = clamp_h(int'(wr_height));
            m_count++;
        end
        complete  = (m_count == 700);
        e_overrun = frame_start && !complete;
        swap      = frame_start && complete;
        nready    = m_req ? 1'b1 : (complete ? 1'b0 : m_ready);
        nreq      = m_fresh || swap;
        m_fresh   = 1'b0;
        m_req     = nreq;
        m_ready   = nready;
        if (swap) begin
            m_sel   = !m_sel;
            m_valid = 1'b1;
            m_count = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("frame_req",  frame_req,  m_req);
        chk("wr_ready",   wr_ready,   m_ready);
        chk("wr_col",     wr_col,     (m_count > 699) ? 699 : m_count);
        chk("disp_sel",   disp_sel,   m_sel);
        chk("disp_valid", disp_valid, m_valid);
        chk("overrun",    overrun,    e_overrun);
        chk("rd_height",  rd_height,  e_rd);
    endtask

    task automatic step(input logic fs, input logic v, input logic [9:0] h, input logic [9:0] rc);
        frame_start = fs; wr_valid = v; wr_height = h; rd_col = rc;
        @(posedge half_clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge half_clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [9:0] rc);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, rc);
    endtask

    task automatic fill(input int upto, input int mode, input logic fs_last);
        int   guard;
        logic done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 3000) begin
            logic v, last;
            v    = (guard % 53) != 7;
            last = v && m_ready && (m_count == upto - 1);
            step(fs_last && last, v, height_of(mode, m_count), 10'((guard * 37) % 1024));
            guard++;
            if (last || m_count >= upto) done = 1'b1;
        end
        chk("fill_bound", {31'd0, done}, 32'd1);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge half_clk);
        check_outputs();
        rst_n = 1'b1;

        step(1'b0, 1'b0, 10'd0, 10'd5);
        chk("req_cycle1", frame_req, 1);
        chk("ready_cycle1", wr_ready, 0);
        step(1'b0, 1'b0, 10'd0, 10'd5);
        chk("ready_cycle2", wr_ready, 1);
        chk("req_cycle2", frame_req, 0);

        // Frame A: h = col
        fill(700, 0, 1'b0);
        idle(3, 10'd123);
        chk("done_ready_low", wr_ready, 0);
        chk("done_wr_col", wr_col, 699);
        step(1'b1, 1'b0, 10'd0, 10'd123);
        chk("swapA_sel", disp_sel, 1);
        chk("swapA_valid", disp_valid, 1);
        chk("swapA_req", frame_req, 1);
        step(1'b0, 1'b0, 10'd0, 10'd123);
        chk("readA_123", rd_height, 123);

        // Frame B: early frame_start overruns, swap waits for completion
        fill(300, 1, 1'b0);
        step(1'b1, 1'b0, 10'd0, 10'd123);
        chk("overrun_pulse", overrun, 1);
        chk("overrun_no_swap", disp_sel, 1);
        chk("overrun_old_read", rd_height, 123);
        fill(700, 1, 1'b0);
        idle(2, 10'd5);
        step(1'b1, 1'b0, 10'd0, 10'd5);
        chk("swapB_sel", disp_sel, 0);
        chk("swapB_old_read", rd_height, 5);
        step(1'b1, 1'b0, 10'd0, 10'd5);
        chk("req_overrun", overrun, 1);
        chk("readB_clamp", rd_height, EXP_900);
        step(1'b0, 1'b0, 10'd0, 10'd700);
        chk("read_col700", rd_height, 0);
        step(1'b0, 1'b0, 10'd0, 10'd1023);
        chk("read_col1023", rd_height, 0);

        // Frame C: last beat coincides with frame_start
        fill(700, 2, 1'b1);
        chk("coinc_overrun", overrun, 0);
        chk("coinc_sel", disp_sel, 1);
        chk("coinc_req", frame_req, 1);
        step(1'b0, 1'b0, 10'd0, 10'd0);
        chk("readC_0", rd_height, 699);
        step(1'b0, 1'b0, 10'd0, 10'd600);
        chk("readC_600", rd_height, 99);

        // Frame D: reset at beat 350 discards the partial frame
        fill(350, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_valid", disp_valid, 0);
        chk("rst_wr_col", wr_col, 0);
        idle(2, 10'd5);
        @(negedge half_clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 10'd0, 10'd5);
        chk("rst_req", frame_req, 1);
        chk("rst_read_zero", rd_height, 0);
        fill(700, 1, 1'b0);
        idle(1, 10'd5);
        step(1'b1, 1'b0, 10'd0, 10'd5);
        chk("swapD_sel", disp_sel, 1);
        step(1'b0, 1'b0, 10'd0, 10'd5);
        chk("readD_5", rd_height, EXP_900);
        step(1'b0, 1'b0, 10'd0, 10'd10);
        chk("readD_10", rd_height, 30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
